tomasulo_machine: RTL and testbench
===================================

Name: tomasulo_machine

Overview:
- Single-issue Tomasulo out-of-order integer core.
- Instructions are accepted in order through a valid/ready port and placed in reservation stations (RS) with register renaming by tag.
- Instructions execute on one ALU and one multiplier out of order and write back over a single common data bus (CDB).
- A top-level harness clocks it; the debug port and CDB outputs expose architectural state for verification.

Parameters:
- XLEN, 32, datapath width.
- MUL_LAT, 3, multiplier latency in cycles from dispatch to CDB request.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  an instruction is presented.
- instr  in  32  fields: op[31:29], rd[28:24], rs1[23:19], rs2[18:14], imm[11:0] (sign-extended).
- instr_ready  out  1  combinational: the instruction can be accepted this cycle.
- cdb_valid  out  1  a result is broadcast this cycle.
- cdb_tag  out  3  producing RS tag.
- cdb_value  out  32  broadcast result.
- dbg_addr  in  5  register-file read address.
- dbg_data  out  32  combinational register value (x0 reads 0).
- busy  out  1  any RS or functional unit occupied.

Behaviour:
- Opcodes:
  - 0 NOP
  - 1 ADD
  - 2 SUB
  - 3 ADDI (rs1+imm)
  - 4 MUL (low 32 bits)
  - 5 AND
  - 6 OR
  - 7 XOR
- Arithmetic wraps modulo 2^32.
- Reservation stations and tags:
  - ALU RS entries use tags 1-4; MUL RS entries use tags 5-6.
  - Tag 0 means "value present". Tag 7 is unused.
- Reset state:
  - Register x[i] = i (x0 = 0).
  - All register status tags = 0.
  - All RS free; units idle.
  - cdb_valid = 0, cdb_tag = 0, cdb_value = 0, busy = 0.
- Issue:
  - instr_ready = 1 when the opcode is NOP, or when a free RS of the required class exists.
  - An instruction is accepted on a rising edge with instr_valid & instr_ready. The lowest-index free RS is used.
  - Each operand is taken from the register file if its status tag is 0, otherwise the status tag is recorded.
  - Same-edge CDB bypass: if the CDB tag equals a needed operand's tag, the CDB value is captured instead.
  - ADDI ignores rs2.
  - rd≠0 sets status[rd] to the new tag. rd=0 never sets status and its result is discarded.
- Operand wakeup: every busy RS with a source tag equal to cdb_tag captures cdb_value on the edge and clears that tag.
- Dispatch:
  - Each edge, the lowest-index RS with both operands ready is sent to its unit if that unit is free.
  - The RS stays allocated until its result is broadcast.
- Execution latency:
  - ALU requests the CDB in the cycle after dispatch.
  - MUL requests the CDB MUL_LAT cycles after dispatch. The multiplier is non-pipelined.
- CDB:
  - One broadcast per cycle. MUL has priority over ALU.
  - A losing ALU holds its result and accepts no new dispatch until granted.
- Writeback, on the broadcast edge:
  - Every register whose status equals cdb_tag takes cdb_value and clears its status.
  - The producing RS is freed.
  - If an issue in the same edge renames that same rd, the new tag wins; the value is still written.
- Timing, ADD with ready operands accepted at edge E0:
  - Dispatch at E1.
  - cdb_valid during the cycle after E1.
  - Register file updated at E2.
  - Matching MUL timing: CDB after E3, write at E4.
- Reset asserted mid-operation aborts all in-flight work and restores the reset state immediately.

Test Plan:
- Reset, then read all registers via dbg_addr -> dbg_data = i for x[i]; busy = 0; instr_ready = 1.
- ADD x3,x1,x2 at E0 -> cdb_valid with tag 1, value 3 in the cycle after E1; dbg x3 = 3 after E2.
- MUL x4,x5,x6 then ADD x7,x4,x1 back-to-back:
  - ADD waits on tag 5; MUL broadcasts 30 after 3 cycles.
  - ADD wakes, broadcasts 31; final x4 = 30, x7 = 31.
- Out-of-order completion: MUL x8,x2,x3 followed by ADDI x9,x1,-1 -> ADDI broadcasts 0 first; MUL broadcasts 6 later.
- Structural stall: issue 5 independent MULs -> instr_ready drops after 2 are accepted, rises when tag 5 is freed; all results are correct.
- CDB collision: MUL and ALU complete in the same cycle -> MUL broadcasts first, ALU the next cycle.
- WAW: the second writer's result remains in rd.
- Reset asserted mid-stream -> state equals reset values.
- ADD x0,x1,x1 -> x0 stays 0.

Source files
------------

// File: rtl/tomasulo_machine.sv
// tomasulo_machine: single-issue Tomasulo integer core.
// Six reservation stations with tag renaming: tags 1-4 feed the ALU and tags 5-6 feed the multiplier.
// One ALU (one cycle) and one non-pipelined multiplier (MUL_LAT cycles) share a single CDB.
// On the CDB the multiplier has priority over the ALU.
module tomasulo_machine #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            cdb_valid,
  output logic [2:0]      cdb_tag,
  output logic [XLEN-1:0] cdb_value,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            busy
);

  localparam int NRS = 6;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  // Architectural state: register values plus the tag of the pending producer for each register.
  logic [XLEN-1:0] rf     [32];
  logic [2:0]      rf_tag [32];

  // Reservation stations: the tag of entry i is i+1.
  logic [NRS-1:0]  rs_busy;
  logic [NRS-1:0]  rs_disp;
  logic [2:0]      rs_op [NRS];
  logic [XLEN-1:0] rs_vj [NRS];
  logic [XLEN-1:0] rs_vk [NRS];
  logic [2:0]      rs_qj [NRS];
  logic [2:0]      rs_qk [NRS];
  logic [NRS-1:0]  rs_ready;

  // Functional units: the result is captured at dispatch and held until the CDB grants it.
  logic            alu_busy;
  logic [2:0]      alu_tag;
  logic [XLEN-1:0] alu_result;
  logic            mul_busy;
  logic [2:0]      mul_tag;
  logic [XLEN-1:0] mul_result;
  logic [7:0]      mul_cnt;

  // Instruction fields
  logic [2:0]      in_op;
  logic [4:0]      in_rd, in_rs1, in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_is_mul;
  logic            unused_ok;

  assign in_op     = instr[31:29];
  assign in_rd     = instr[28:24];
  assign in_rs1    = instr[23:19];
  assign in_rs2    = instr[18:14];
  assign in_imm    = {{(XLEN-12){instr[11]}}, instr[11:0]};
  assign in_is_mul = (in_op == OP_MUL);
  assign unused_ok = &{1'b0, instr[13:12]};

  logic            alu_free_found, mul_free_found;
  logic [2:0]      alu_free_idx, mul_free_idx, alloc_idx, new_tag;
  logic            issue_ok;
  logic [2:0]      src1_tag, src2_tag, src1_q, src2_q;
  logic [XLEN-1:0] src1_val, src2_val;
  logic            mul_req, alu_grant, alu_unit_free, mul_unit_free;
  logic            alu_disp, mul_disp;
  logic [2:0]      alu_sel, mul_sel;

  function automatic logic [XLEN-1:0] alu_calc(input logic [2:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    r = '0;
    case (op)
      OP_ADD, OP_ADDI: r = a + b;
      OP_SUB:          r = a - b;
      OP_AND:          r = a & b;
      OP_OR:           r = a | b;
      OP_XOR:          r = a ^ b;
      default:         r = '0;
    endcase
    return r;
  endfunction

  // An entry may dispatch once it holds both operand values and has not yet been sent to its unit.
  for (genvar gi = 0; gi < NRS; gi++) begin : g_rs_ready
    assign rs_ready[gi] = rs_busy[gi] & ~rs_disp[gi] & (rs_qj[gi] == 3'd0) & (rs_qk[gi] == 3'd0);
  end

  // Find the lowest-index free entry in each RS class, and derive the issue handshake.
  always_comb begin
    alu_free_found = 1'b0;
    alu_free_idx   = 3'd0;
    mul_free_found = 1'b0;
    mul_free_idx   = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_busy[i]) begin
        alu_free_found = 1'b1;
        alu_free_idx   = 3'(i);
      end
    end
    for (int i = 5; i >= 4; i--) begin
      if (!rs_busy[i]) begin
        mul_free_found = 1'b1;
        mul_free_idx   = 3'(i);
      end
    end
    instr_ready = (in_op == OP_NOP) || (in_is_mul ? mul_free_found : alu_free_found);
    issue_ok    = instr_valid && instr_ready && (in_op != OP_NOP);
    alloc_idx   = in_is_mul ? mul_free_idx : alu_free_idx;
    new_tag     = alloc_idx + 3'd1;
  end

  // Operand capture at issue: register value, same-edge CDB bypass, or the producer's tag.
  always_comb begin
    src1_tag = rf_tag[in_rs1];
    src1_val = rf[in_rs1];
    src1_q   = 3'd0;
    if (src1_tag != 3'd0) begin
      if (cdb_valid && (cdb_tag == src1_tag)) begin
        src1_val = cdb_value;
      end else begin
        src1_val = '0;
        src1_q   = src1_tag;
      end
    end
    src2_tag = rf_tag[in_rs2];
    src2_val = rf[in_rs2];
    src2_q   = 3'd0;
    if (in_op == OP_ADDI) begin
      src2_val = in_imm;
    end else if (src2_tag != 3'd0) begin
      if (cdb_valid && (cdb_tag == src2_tag)) begin
        src2_val = cdb_value;
      end else begin
        src2_val = '0;
        src2_q   = src2_tag;
      end
    end
  end

  // CDB arbitration and dispatch selection. A unit granted this edge may accept a new op on the same edge.
  always_comb begin
    mul_req       = mul_busy && (mul_cnt == 8'd0);
    alu_grant     = alu_busy && !mul_req;
    alu_unit_free = !alu_busy || alu_grant;
    mul_unit_free = !mul_busy || mul_req;
    cdb_valid     = mul_req || alu_busy;
    cdb_tag       = 3'd0;
    cdb_value     = '0;
    if (mul_req) begin
      cdb_tag   = mul_tag;
      cdb_value = mul_result;
    end else if (alu_busy) begin
      cdb_tag   = alu_tag;
      cdb_value = alu_result;
    end
    alu_disp = 1'b0;
    alu_sel  = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rs_ready[i]) begin
        alu_disp = 1'b1;
        alu_sel  = 3'(i);
      end
    end
    alu_disp = alu_disp && alu_unit_free;
    mul_disp = 1'b0;
    mul_sel  = 3'd4;
    for (int i = 5; i >= 4; i--) begin
      if (rs_ready[i]) begin
        mul_disp = 1'b1;
        mul_sel  = 3'(i);
      end
    end
    mul_disp = mul_disp && mul_unit_free;
  end

  assign dbg_data = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];
  assign busy     = (|rs_busy) | alu_busy | mul_busy;

  // Register file and rename table: CDB writeback first, then a same-edge rename overrides the tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        rf[i]     <= XLEN'(i);
        rf_tag[i] <= 3'd0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (cdb_valid && (rf_tag[i] == cdb_tag)) begin
          rf[i]     <= cdb_value;
          rf_tag[i] <= 3'd0;
        end
      end
      if (issue_ok && (in_rd != 5'd0)) begin
        rf_tag[in_rd] <= new_tag;
      end
    end
  end

  // Reservation stations: free on broadcast, wake operands from the CDB, mark dispatch, allocate on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_busy <= '0;
      rs_disp <= '0;
      for (int i = 0; i < NRS; i++) begin
        rs_op[i] <= OP_NOP;
        rs_vj[i] <= '0;
        rs_vk[i] <= '0;
        rs_qj[i] <= 3'd0;
        rs_qk[i] <= 3'd0;
      end
    end else begin
      for (int i = 0; i < NRS; i++) begin
        if (cdb_valid && rs_busy[i] && (cdb_tag == 3'(i + 1))) begin
          rs_busy[i] <= 1'b0;
          rs_disp[i] <= 1'b0;
        end
        if (cdb_valid && (rs_qj[i] == cdb_tag)) begin
          rs_vj[i] <= cdb_value;
          rs_qj[i] <= 3'd0;
        end
        if (cdb_valid && (rs_qk[i] == cdb_tag)) begin
          rs_vk[i] <= cdb_value;
          rs_qk[i] <= 3'd0;
        end
        if ((alu_disp && (alu_sel == 3'(i))) || (mul_disp && (mul_sel == 3'(i)))) begin
          rs_disp[i] <= 1'b1;
        end
        if (issue_ok && (alloc_idx == 3'(i))) begin
          rs_busy[i] <= 1'b1;
          rs_disp[i] <= 1'b0;
          rs_op[i]   <= in_op;
          rs_vj[i]   <= src1_val;
          rs_qj[i]   <= src1_q;
          rs_vk[i]   <= src2_val;
          rs_qk[i]   <= src2_q;
        end
      end
    end
  end

  // Functional units: compute at dispatch, count down multiplier latency, release when granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_busy   <= 1'b0;
      alu_tag    <= 3'd0;
      alu_result <= '0;
      mul_busy   <= 1'b0;
      mul_tag    <= 3'd0;
      mul_result <= '0;
      mul_cnt    <= 8'd0;
    end else begin
      if (alu_grant) begin
        alu_busy <= 1'b0;
      end
      if (alu_disp) begin
        alu_busy   <= 1'b1;
        alu_tag    <= alu_sel + 3'd1;
        alu_result <= alu_calc(rs_op[alu_sel], rs_vj[alu_sel], rs_vk[alu_sel]);
      end
      if (mul_req) begin
        mul_busy <= 1'b0;
      end else if (mul_busy && (mul_cnt != 8'd0)) begin
        mul_cnt <= mul_cnt - 8'd1;
      end
      if (mul_disp) begin
        mul_busy   <= 1'b1;
        mul_tag    <= mul_sel + 3'd1;
        mul_result <= rs_vj[mul_sel] * rs_vk[mul_sel];
        mul_cnt    <= 8'(MUL_LAT - 1);
      end
    end
  end

endmodule

// File: tb/tb_tomasulo_machine.sv
// tb_tomasulo_machine: directed self-checking bench for tomasulo_machine.
// Expected values and cycle numbers are hand-computed from the reset register contents (x[i] = i).
module tb_tomasulo_machine;

  localparam logic [2:0] ADD = 3'd1, SUB = 3'd2, ADDI = 3'd3, MUL = 3'd4;
  localparam logic [2:0] AND_ = 3'd5, OR_ = 3'd6, XOR_ = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        instr_ready;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  tag;
    logic [31:0] val;
    int          cyc;
  } bcast_t;
  bcast_t bq[$];

  always #5 clk = ~clk;

  tomasulo_machine #(.XLEN(32), .MUL_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every CDB broadcast with the cycle it appeared in.
  always @(negedge clk) begin
    if (rst_n && cdb_valid) begin
      bq.push_back('{cdb_tag, cdb_value, cyc});
      $display("cdb  cycle %0d tag %0d value 0x%08h", cyc, cdb_tag, cdb_value);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [11:0] imm);
    return {op, rd, rs1, rs2, 2'b00, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait (bounded) for ready, return the cycle index of the accepting edge.
  task automatic issue(input logic [31:0] ins, output int e);
    int n;
    n = 0;
    instr = ins;
    instr_valid = 1'b1;
    #1;
    while (!instr_ready && n < 100) begin
      tick();
      n++;
    end
    check("issue_ready", 32'(instr_ready), 32'd1);
    tick();
    e = cyc;
    instr_valid = 1'b0;
    instr = 32'd0;
    $display("issue cycle %0d instr 0x%08h", e, ins);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_reg(input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check($sformatf("x%0d", a), dbg_data, exp);
  endtask

  task automatic check_bc(input string tag, input int idx, input logic [2:0] etag,
                          input logic [31:0] eval, input int ecyc);
    bcast_t b;
    b = bq[idx];
    check({tag, "_tag"}, 32'(b.tag), 32'(etag));
    check({tag, "_val"}, b.val, eval);
    check({tag, "_cyc"}, 32'(b.cyc), 32'(ecyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, e2, n;

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    instr = mk(ADD, 5'd3, 5'd1, 5'd2, 12'd0);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    check("rst_cdb_value", cdb_value, 32'd0);
    for (int i = 0; i < 32; i++) check_reg(5'(i), 32'(i));
    instr = 32'd0;

    // ADD x3,x1,x2: CDB in the cycle after dispatch, register written one edge later
    bq.delete();
    issue(mk(ADD, 5'd3, 5'd1, 5'd2, 12'd0), e0);
    check("add_cdb_early", 32'(cdb_valid), 32'd0);
    tick();
    check("add_cdb_valid", 32'(cdb_valid), 32'd1);
    check("add_cdb_tag", 32'(cdb_tag), 32'd1);
    check("add_cdb_value", cdb_value, 32'd3);
    tick();
    check("add_cdb_done", 32'(cdb_valid), 32'd0);
    check("add_busy", 32'(busy), 32'd0);
    check_reg(5'd3, 32'd3);

    // SUB wraps modulo 2^32
    issue(mk(SUB, 5'd11, 5'd2, 5'd5, 12'd0), e0);
    drain("sub_drain");
    check_reg(5'd11, 32'hFFFF_FFFD);

    // MUL x4,x5,x6 then dependent ADD x7,x4,x1
    bq.delete();
    issue(mk(MUL, 5'd4, 5'd5, 5'd6, 12'd0), e0);
    issue(mk(ADD, 5'd7, 5'd4, 5'd1, 12'd0), e1);
    drain("dep_drain");
    check("dep_count", 32'(bq.size()), 32'd2);
    check_bc("dep_mul", 0, 3'd5, 32'd30, e0 + 3);
    check_bc("dep_add", 1, 3'd1, 32'd31, e0 + 5);
    check_reg(5'd4, 32'd30);
    check_reg(5'd7, 32'd31);

    // Out-of-order completion: ADDI finishes before the earlier MUL
    bq.delete();
    issue(mk(MUL, 5'd8, 5'd2, 5'd3, 12'd0), e0);
    issue(mk(ADDI, 5'd9, 5'd1, 5'd0, 12'hFFF), e1);
    drain("ooo_drain");
    check("ooo_count", 32'(bq.size()), 32'd2);
    check_bc("ooo_addi", 0, 3'd1, 32'd0, e0 + 2);
    check_bc("ooo_mul", 1, 3'd5, 32'd6, e0 + 3);
    check_reg(5'd8, 32'd6);
    check_reg(5'd9, 32'd0);

    // Structural stall: only two MUL stations
    issue(mk(MUL, 5'd15, 5'd20, 5'd21, 12'd0), e0);
    issue(mk(MUL, 5'd16, 5'd22, 5'd23, 12'd0), e1);
    instr = mk(MUL, 5'd17, 5'd24, 5'd25, 12'd0);
    instr_valid = 1'b1;
    #1;
    check("stall_ready_low", 32'(instr_ready), 32'd0);
    n = 0;
    while (!instr_ready && n < 50) begin
      tick();
      n++;
    end
    check("stall_ready_cyc", 32'(cyc), 32'(e0 + 4));
    issue(mk(MUL, 5'd17, 5'd24, 5'd25, 12'd0), e2);
    issue(mk(MUL, 5'd18, 5'd26, 5'd27, 12'd0), e2);
    issue(mk(MUL, 5'd19, 5'd28, 5'd29, 12'd0), e2);
    drain("stall_drain");
    check_reg(5'd15, 32'd420);
    check_reg(5'd16, 32'd506);
    check_reg(5'd17, 32'd600);
    check_reg(5'd18, 32'd702);
    check_reg(5'd19, 32'd812);

    // Logic ops
    issue(mk(AND_, 5'd24, 5'd6, 5'd3, 12'd0), e0);
    issue(mk(OR_, 5'd25, 5'd5, 5'd2, 12'd0), e0);
    issue(mk(XOR_, 5'd26, 5'd6, 5'd3, 12'd0), e0);
    drain("logic_drain");
    check_reg(5'd24, 32'd2);
    check_reg(5'd25, 32'd7);
    check_reg(5'd26, 32'd5);

    // CDB collision: MUL wins, ALU follows one cycle later
    bq.delete();
    issue(mk(MUL, 5'd10, 5'd2, 5'd3, 12'd0), e0);
    tick();
    issue(mk(ADD, 5'd11, 5'd1, 5'd2, 12'd0), e1);
    check("col_issue_cyc", 32'(e1), 32'(e0 + 2));
    drain("col_drain");
    check("col_count", 32'(bq.size()), 32'd2);
    check_bc("col_mul", 0, 3'd5, 32'd6, e0 + 3);
    check_bc("col_alu", 1, 3'd1, 32'd3, e0 + 4);
    check_reg(5'd10, 32'd6);
    check_reg(5'd11, 32'd3);

    // Same-edge CDB bypass at issue
    issue(mk(MUL, 5'd22, 5'd2, 5'd3, 12'd0), e0);
    tick();
    tick();
    tick();
    check("byp_cdb_valid", 32'(cdb_valid), 32'd1);
    check("byp_cdb_tag", 32'(cdb_tag), 32'd5);
    issue(mk(ADD, 5'd23, 5'd22, 5'd1, 12'd0), e1);
    drain("byp_drain");
    check_reg(5'd22, 32'd6);
    check_reg(5'd23, 32'd7);

    // WAW: the later writer's value remains
    issue(mk(MUL, 5'd12, 5'd5, 5'd6, 12'd0), e0);
    issue(mk(ADDI, 5'd12, 5'd1, 5'd0, 12'd100), e1);
    drain("waw1_drain");
    check_reg(5'd12, 32'd101);
    issue(mk(ADDI, 5'd13, 5'd0, 5'd0, 12'd7), e0);
    issue(mk(MUL, 5'd13, 5'd2, 5'd3, 12'd0), e1);
    drain("waw2_drain");
    check_reg(5'd13, 32'd6);

    // rd = x0: result broadcast but discarded
    bq.delete();
    issue(mk(ADD, 5'd0, 5'd1, 5'd1, 12'd0), e0);
    drain("x0_drain");
    check("x0_count", 32'(bq.size()), 32'd1);
    check_bc("x0_add", 0, 3'd1, 32'd2, e0 + 1);
    check_reg(5'd0, 32'd0);
    check_reg(5'd1, 32'd1);

    // Reset mid-stream
    issue(mk(MUL, 5'd1, 5'd2, 5'd3, 12'd0), e0);
    issue(mk(ADD, 5'd2, 5'd1, 5'd1, 12'd0), e1);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("mid_rst_cdb_tag", 32'(cdb_tag), 32'd0);
    check("mid_rst_cdb_value", cdb_value, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) check_reg(5'(i), 32'(i));
    issue(mk(ADD, 5'd5, 5'd1, 5'd2, 12'd0), e0);
    drain("post_rst_drain");
    check_reg(5'd5, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
